uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmitter among NREQ byte-stream requesters. It accepts bytes over per-requester valid/ready handshakes, issues a one-cycle start strobe with held data to the transmitter, and waits for the transmitter's frame-done pulse before issuing the next byte. Multi-byte packets (marked by a last flag) keep the grant locked so frames from different requesters never interleave. The block sits between the command/packet sources and the UART TX core, mirroring the RX core on the receive side.

## Interface

- NREQ, 4: number of requesters (≥2)
- DBITS, 8: data bits per frame; must match the TX core
- HOLD_TIMEOUT, 64: cycles a locked, non-last packet may stall before the lock is released (≥1)

- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_req_valid  in  NREQ  per-requester byte valid; once high, must stay high with stable data/last until the matching ready
- i_req_data  in  NREQ*DBITS  requester k's byte at [k*DBITS +: DBITS]
- i_req_last  in  NREQ  byte is the final byte of a packet
- o_req_ready  out  NREQ  one-hot accept pulse; the handshake completes when ready & valid are both high
- o_grant  out  NREQ  one-hot current owner; all zero in IDLE
- o_busy  out  1  high whenever state ≠ IDLE
- o_tx_start  out  1  one-cycle strobe to the TX core
- o_tx_data  out  DBITS  byte to transmit; held stable from the start strobe until i_tx_done
- i_tx_done  in  1  one-cycle pulse from the TX core at the end of the stop bit(s)

## Operation

- States: IDLE, LOAD, START, WAIT, HOLD.
- Internal registers:
  - grant index g
  - round-robin pointer ptr (0..NREQ-1)
  - tx_data and last_q
  - hold counter hcnt, width $clog2(HOLD_TIMEOUT+1)
- IDLE:
  - If any i_req_valid is high, pick the winner: the first set index searching ptr, ptr+1, … mod NREQ.
  - Register g = winner and go to LOAD.
  - With no valid, stay in IDLE.
- LOAD:
  - o_req_ready[g]=1 for exactly this cycle.
  - Capture i_req_data[g] into tx_data and i_req_last[g] into last_q.
  - Go to START.
  - Valid is guaranteed high by the handshake rule.
- START: o_tx_start=1 for one cycle, then go to WAIT.
- WAIT: on i_tx_done:
  - last_q=1: release. ptr = (g+1) mod NREQ; go to IDLE.
  - last_q=0 and i_req_valid[g]=1: go to LOAD (lock kept).
  - last_q=0 and i_req_valid[g]=0: clear hcnt, go to HOLD.
- HOLD:
  - i_req_valid[g]=1: go to LOAD.
  - Otherwise hcnt increments each cycle.
  - When hcnt == HOLD_TIMEOUT-1 with valid still low: release. ptr = (g+1) mod NREQ; go to IDLE.
  - When valid rises on the same cycle as the timeout, valid wins and the FSM goes to LOAD.
- Other requesters' valids are ignored while locked; they receive no ready.
- i_tx_done in any state other than WAIT is ignored.
- o_grant is one-hot of g in LOAD/START/WAIT/HOLD, and zero in IDLE.
- o_tx_data is driven from tx_data at all times and only changes in LOAD.
- Illegal state encoding → IDLE.

## Timing

- Reset values:
  - All outputs 0: o_req_ready, o_grant, o_busy, o_tx_start, o_tx_data.
  - state=IDLE, ptr=0, g=0, last_q=0, hcnt=0.
- Reset asserted mid-operation aborts immediately. No done or ready is emitted afterward. The TX core is reset by the same net.
- Latency: valid sampled high in IDLE at cycle n → ready at n+1 → tx_start at n+2.
- Inter-byte gap within a locked packet: i_tx_done at cycle m (valid already high) → ready at m+1, tx_start at m+2.
- Between packets: i_tx_done at m → IDLE at m+1 → next LOAD at m+2 at the earliest.
- o_busy rises the cycle after the winning valid is sampled and falls the cycle after release.

## Test plan

1. Single byte, no contention:
   - Stimulus: req1 valid, data=0xA5, last=1, from cycle 0; pulse i_tx_done 20 cycles after start.
   - Response: ready[1] at cycle 1, tx_start at cycle 2 with o_tx_data=0xA5, o_busy low after done; ptr=2.
2. Round-robin fairness:
   - Stimulus: all 4 valid, single-byte packets, continuously.
   - Response: service order 0,1,2,3,0; each requester gets exactly one ready per round.
3. Packet lock:
   - Stimulus: req2 sends 3 bytes (0x11, 0x22, 0x33 with last on the third) while req0 and req3 are valid.
   - Response: three consecutive tx_starts carry 0x11/0x22/0x33, with no ready to req0 or req3 until req2's last done; req3 wins next.
4. Hold timeout:
   - Stimulus: HOLD_TIMEOUT=8; req0 drops valid after a non-last byte.
   - Response: release exactly 8 cycles after entering HOLD; req1 granted next.
   - Repeat with valid returning at cycle 5 of HOLD → LOAD, lock kept.
5. Spurious done: pulse i_tx_done in IDLE, LOAD and HOLD → no state change, no ready, no tx_start.
6. Reset mid-frame:
   - Stimulus: assert i_rst_n low during WAIT.
   - Response: all outputs 0 within the same cycle. After release, req0 is served first (ptr=0).

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NREQ byte-stream
// requesters, holding the grant for the duration of a multi-byte packet.
module uart_tx_arbiter #(
    parameter int NREQ         = 4,
    parameter int DBITS        = 8,
    parameter int HOLD_TIMEOUT = 64
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NREQ-1:0]         i_req_valid,
    input  logic [NREQ*DBITS-1:0]   i_req_data,
    input  logic [NREQ-1:0]         i_req_last,
    output logic [NREQ-1:0]         o_req_ready,
    output logic [NREQ-1:0]         o_grant,
    output logic                    o_busy,
    output logic                    o_tx_start,
    output logic [DBITS-1:0]        o_tx_data,
    input  logic                    i_tx_done
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HW = $clog2(HOLD_TIMEOUT + 1);
    localparam logic [HW-1:0] HLIM = HW'(HOLD_TIMEOUT - 1);
    localparam logic [GW-1:0] GMAX = GW'(NREQ - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     g_q, g_d;
    logic [GW-1:0]     ptr_q, ptr_d;
    logic [DBITS-1:0]  tx_data_q, tx_data_d;
    logic              last_q, last_d;
    logic [HW-1:0]     hcnt_q, hcnt_d;
    logic [NREQ-1:0]   ready_q, grant_q;
    logic              busy_q, start_q;

    // First valid requester at or after the pointer, wrapping modulo NREQ.
    function automatic logic [GW-1:0] pick_winner(input logic [NREQ-1:0] v, input logic [GW-1:0] p);
        logic [GW-1:0] w;
        logic [GW:0]   idx;
        logic          found;
        w     = p;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = {1'b0, p} + (GW+1)'(i);
            if (idx >= (GW+1)'(NREQ)) begin
                idx = idx - (GW+1)'(NREQ);
            end else begin
                idx = idx;
            end
            if (!found && v[idx[GW-1:0]]) begin
                w     = idx[GW-1:0];
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return w;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [GW-1:0] idx);
        logic [NREQ-1:0] r;
        r      = {NREQ{1'b0}};
        r[idx] = 1'b1;
        return r;
    endfunction

    function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] idx);
        return (idx == GMAX) ? {GW{1'b0}} : idx + GW'(1);
    endfunction

    // Next-state and datapath decisions for the arbitration sequencer.
    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        ptr_d     = ptr_q;
        tx_data_d = tx_data_q;
        last_d    = last_q;
        hcnt_d    = hcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|i_req_valid) begin
                    g_d     = pick_winner(i_req_valid, ptr_q);
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                tx_data_d = i_req_data[g_q*DBITS +: DBITS];
                last_d    = i_req_last[g_q];
                state_d   = ST_START;
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!i_tx_done) begin
                    state_d = ST_WAIT;
                end else if (last_q) begin
                    ptr_d   = next_idx(g_q);
                    state_d = ST_IDLE;
                end else if (i_req_valid[g_q]) begin
                    state_d = ST_LOAD;
                end else begin
                    hcnt_d  = {HW{1'b0}};
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // A returning valid beats the timeout on the same cycle.
                if (i_req_valid[g_q]) begin
                    state_d = ST_LOAD;
                end else if (hcnt_q == HLIM) begin
                    ptr_d   = next_idx(g_q);
                    state_d = ST_IDLE;
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; outputs follow the state being entered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            g_q       <= {GW{1'b0}};
            ptr_q     <= {GW{1'b0}};
            tx_data_q <= {DBITS{1'b0}};
            last_q    <= 1'b0;
            hcnt_q    <= {HW{1'b0}};
            ready_q   <= {NREQ{1'b0}};
            grant_q   <= {NREQ{1'b0}};
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            ptr_q     <= ptr_d;
            tx_data_q <= tx_data_d;
            last_q    <= last_d;
            hcnt_q    <= hcnt_d;
            ready_q   <= (state_d == ST_LOAD) ? onehot(g_d) : {NREQ{1'b0}};
            grant_q   <= (state_d != ST_IDLE) ? onehot(g_d) : {NREQ{1'b0}};
            busy_q    <= (state_d != ST_IDLE);
            start_q   <= (state_d == ST_START);
        end
    end

    assign o_req_ready = ready_q;
    assign o_grant     = grant_q;
    assign o_busy      = busy_q;
    assign o_tx_start  = start_q;
    assign o_tx_data   = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: latency, round-robin order, packet lock,
// hold timeout, spurious done and mid-frame reset.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  last;
    logic        done;
    logic [3:0]  ready, grant;
    logic        busy, start;
    logic [7:0]  txd;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NREQ(4), .DBITS(8), .HOLD_TIMEOUT(8)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (valid),
        .i_req_data  (data),
        .i_req_last  (last),
        .o_req_ready (ready),
        .o_grant     (grant),
        .o_busy      (busy),
        .o_tx_start  (start),
        .o_tx_data   (txd),
        .i_tx_done   (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        valid = 4'b0000;
        last  = 4'b0000;
        data  = 32'h0;
        done  = 1'b0;
        tick();
        check_eq({tag, ".rst_ready"}, 32'(ready), 32'h0);
        check_eq({tag, ".rst_grant"}, 32'(grant), 32'h0);
        check_eq({tag, ".rst_busy"},  32'(busy),  32'h0);
        check_eq({tag, ".rst_start"}, 32'(start), 32'h0);
        check_eq({tag, ".rst_data"},  32'(txd),   32'h0);
        rst_n = 1'b1;
    endtask

    // One byte: LOAD after the next edge, START, WAIT, then done raised
    // (sampled by the following edge, which the caller or next xfer supplies).
    task automatic xfer(input string tag, input int k, input logic [7:0] exp_d,
                        input logic nv, input logic [7:0] nd, input logic nl);
        logic [3:0] oh;
        oh = 4'b0001 << k;
        tick();
        done = 1'b0;
        check_eq({tag, ".ready"}, 32'(ready), 32'(oh));
        check_eq({tag, ".grant"}, 32'(grant), 32'(oh));
        check_eq({tag, ".busy"},  32'(busy),  32'h1);
        tick();
        check_eq({tag, ".start"}, 32'(start), 32'h1);
        check_eq({tag, ".data"},  32'(txd),   32'(exp_d));
        check_eq({tag, ".ready_off"}, 32'(ready), 32'h0);
        valid[k]        = nv;
        data[k*8 +: 8]  = nd;
        last[k]         = nl;
        tick();
        check_eq({tag, ".start_off"}, 32'(start), 32'h0);
        check_eq({tag, ".data_held"}, 32'(txd),   32'(exp_d));
        check_eq({tag, ".wait_ready"}, 32'(ready), 32'h0);
        tick();
        done = 1'b1;
    endtask

    task automatic idle_gap(input string tag);
        tick();
        done = 1'b0;
        check_eq({tag, ".idle_busy"},  32'(busy),  32'h0);
        check_eq({tag, ".idle_grant"}, 32'(grant), 32'h0);
    endtask

    task automatic hold_return(input string tag, input int n);
        do_reset(tag);
        valid[0] = 1'b1; data[7:0] = 8'h42; last[0] = 1'b0;
        xfer({tag, ".b0"}, 0, 8'h42, 1'b0, 8'h00, 1'b0);
        tick();
        done = 1'b0;
        valid[1] = 1'b1; data[15:8] = 8'h51; last[1] = 1'b1;
        repeat (n) tick();
        check_eq({tag, ".still_hold"}, 32'(grant), 32'h1);
        valid[0] = 1'b1; data[7:0] = 8'h43; last[0] = 1'b1;
        xfer({tag, ".b1"}, 0, 8'h43, 1'b0, 8'h00, 1'b0);
        idle_gap(tag);
        xfer({tag, ".next"}, 1, 8'h51, 1'b0, 8'h00, 1'b0);
        idle_gap({tag, ".n"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int ord [5] = '{0, 1, 2, 3, 0};

        // Single byte, then pointer must have moved to 2.
        do_reset("t1");
        valid[1] = 1'b1; data[15:8] = 8'hA5; last[1] = 1'b1;
        xfer("t1", 1, 8'hA5, 1'b0, 8'h00, 1'b0);
        idle_gap("t1");
        valid = 4'b0111; last = 4'b0111; data[7:0] = 8'h01; data[15:8] = 8'h02; data[23:16] = 8'h03;
        xfer("t1ptr", 2, 8'h03, 1'b0, 8'h00, 1'b0);
        idle_gap("t1ptr");

        // Round-robin with everyone continuously valid.
        do_reset("t2");
        valid = 4'b1111; last = 4'b1111; data = 32'h33221100;
        for (int r = 0; r < 5; r++) begin
            xfer($sformatf("t2.r%0d", r), ord[r], 8'(ord[r] * 17), 1'b1, 8'(ord[r] * 17), 1'b1);
            idle_gap($sformatf("t2.r%0d", r));
        end

        // Packet lock for req2 while req0/req3 wait.
        do_reset("t3");
        valid[1] = 1'b1; data[15:8] = 8'h10; last[1] = 1'b1;
        xfer("t3pre", 1, 8'h10, 1'b0, 8'h00, 1'b0);
        idle_gap("t3pre");
        valid = 4'b1101; last = 4'b1001; data = 32'hD3_11_00_C0;
        xfer("t3b0", 2, 8'h11, 1'b1, 8'h22, 1'b0);
        xfer("t3b1", 2, 8'h22, 1'b1, 8'h33, 1'b1);
        xfer("t3b2", 2, 8'h33, 1'b0, 8'h00, 1'b0);
        idle_gap("t3b2");
        xfer("t3r3", 3, 8'hD3, 1'b0, 8'h00, 1'b0);
        idle_gap("t3r3");
        xfer("t3r0", 0, 8'hC0, 1'b0, 8'h00, 1'b0);
        idle_gap("t3r0");

        // Hold timeout: release exactly 8 cycles after entering HOLD.
        do_reset("t4");
        valid[0] = 1'b1; data[7:0] = 8'h40; last[0] = 1'b0;
        xfer("t4b0", 0, 8'h40, 1'b0, 8'h00, 1'b0);
        tick();
        done = 1'b0;
        valid[1] = 1'b1; data[15:8] = 8'h51; last[1] = 1'b1;
        check_eq("t4.hold_busy", 32'(busy), 32'h1);
        for (int i = 1; i < 8; i++) begin
            tick();
            check_eq($sformatf("t4.hold%0d_grant", i), 32'(grant), 32'h1);
            check_eq($sformatf("t4.hold%0d_ready", i), 32'(ready), 32'h0);
        end
        tick();
        check_eq("t4.release_busy", 32'(busy), 32'h0);
        xfer("t4r1", 1, 8'h51, 1'b0, 8'h00, 1'b0);
        idle_gap("t4r1");

        hold_return("t4v5", 5);
        hold_return("t4v7", 7);

        // Spurious done in IDLE, LOAD and HOLD.
        do_reset("t5");
        done = 1'b1;
        tick();
        done = 1'b0;
        check_eq("t5.idle_busy",  32'(busy),  32'h0);
        check_eq("t5.idle_ready", 32'(ready), 32'h0);
        check_eq("t5.idle_start", 32'(start), 32'h0);
        valid[2] = 1'b1; data[23:16] = 8'h77; last[2] = 1'b0;
        done = 1'b1;
        tick();
        check_eq("t5.load_ready", 32'(ready), 32'h4);
        tick();
        check_eq("t5.load_start", 32'(start), 32'h1);
        check_eq("t5.load_data",  32'(txd),   32'h77);
        done = 1'b0; valid[2] = 1'b0;
        tick();
        done = 1'b1;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        check_eq("t5.hold_busy",  32'(busy),  32'h1);
        check_eq("t5.hold_grant", 32'(grant), 32'h4);
        check_eq("t5.hold_start", 32'(start), 32'h0);
        check_eq("t5.hold_ready", 32'(ready), 32'h0);
        repeat (6) tick();
        check_eq("t5.hold7_busy", 32'(busy), 32'h1);
        tick();
        check_eq("t5.release_busy", 32'(busy), 32'h0);

        // Reset during WAIT clears outputs at once; req0 first afterwards.
        do_reset("t6");
        valid[2] = 1'b1; data[23:16] = 8'h66; last[2] = 1'b1;
        tick();
        tick();
        valid[2] = 1'b0;
        tick();
        check_eq("t6.wait_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check_eq("t6.ready", 32'(ready), 32'h0);
        check_eq("t6.grant", 32'(grant), 32'h0);
        check_eq("t6.busy",  32'(busy),  32'h0);
        check_eq("t6.start", 32'(start), 32'h0);
        check_eq("t6.data",  32'(txd),   32'h0);
        tick();
        rst_n = 1'b1;
        valid = 4'b0101; last = 4'b0101; data = 32'h00_02_00_01;
        xfer("t6r0", 0, 8'h01, 1'b0, 8'h00, 1'b0);
        idle_gap("t6r0");
        xfer("t6r2", 2, 8'h02, 1'b0, 8'h00, 1'b0);
        idle_gap("t6r2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
